// File: rtl/hwmath_shift_pkg.sv
// Shared operation encoding for the pipelined barrel shifter.
// The op width is 2 bits wide and all submodules share it.
package hwmath_shift_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/barrel_shifter_pipe_shift_level.sv
// One power-of-two shift level (module shift_level); sticky accumulation is built
// only when SHIFTER_STICKY_EN is defined, otherwise sticky passes straight through.
module shift_level
    import hwmath_shift_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  shift_op_e        op,
    input  logic             enable,
    input  logic             sticky_in,
    output logic [WIDTH-1:0] data_out,
    output logic             sticky_out
);

    logic signed [WIDTH-1:0] sdata;
    assign sdata = data_in;

    always_comb begin
        data_out = data_in;
        if (enable) begin
            case (op)
                OP_LSL:  data_out = data_in << DIST;
                OP_LSR:  data_out = data_in >> DIST;
                OP_ASR:  data_out = sdata >>> DIST;
                default: data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
            endcase
        end
    end

`ifdef SHIFTER_STICKY_EN
    // Only right shifts lose bits past bit 0; rotates keep everything.
    assign sticky_out = sticky_in |
                        (enable && (op == OP_LSR || op == OP_ASR) && (|data_in[DIST-1:0]));
`else
    assign sticky_out = sticky_in;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with valid/ready flow control and tag sideband.
// Define SHIFTER_STICKY_EN to build the shifted-out sticky flag; otherwise out_sticky is 0.
module barrel_shifter_pipe
    import hwmath_shift_pkg::*;
#(
    parameter  int WIDTH  = 48,
    parameter  int STAGES = 2,
    parameter  int TAG_W  = 4,
    localparam int AWIDTH = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [AWIDTH-1:0] in_shamt,
    input  logic [OP_W-1:0]   in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_sticky,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LPS = (AWIDTH + STAGES - 1) / STAGES;

    // Level k (k = 0 is the largest distance) belongs to this stage; overflow lands in the last one.
    function automatic int stage_of(input int k);
        return ((k / LPS) < (STAGES - 1)) ? (k / LPS) : (STAGES - 1);
    endfunction

    logic              stg_in_valid  [STAGES];
    logic [WIDTH-1:0]  stg_in_data   [STAGES];
    shift_op_e         stg_in_op     [STAGES];
    logic [AWIDTH-1:0] stg_in_shamt  [STAGES];
    logic [TAG_W-1:0]  stg_in_tag    [STAGES];
    logic              stg_in_sticky [STAGES];
    logic [WIDTH-1:0]  stg_out_data  [STAGES];
    logic              stg_out_sticky[STAGES];
    logic              stg_ready     [STAGES];

    logic [WIDTH-1:0]  lvl_data      [AWIDTH];
    logic              lvl_sticky    [AWIDTH];

    logic              valid_reg     [STAGES];
    logic [STAGES-1:0] valid_vec;
    logic [WIDTH-1:0]  data_reg      [STAGES];
    shift_op_e         op_reg        [STAGES];
    logic [AWIDTH-1:0] shamt_reg     [STAGES];
    logic [TAG_W-1:0]  tag_reg       [STAGES];
`ifdef SHIFTER_STICKY_EN
    logic              sticky_reg    [STAGES];
`endif

    genvar gi;

    for (gi = 0; gi < AWIDTH; gi++) begin : g_level
        localparam int  ST    = stage_of(gi);
        localparam bit  FIRST = (gi == 0) || (stage_of(gi - 1) != ST);
        logic [WIDTH-1:0] d_in;
        logic             s_in;

        if (FIRST) begin : g_first
            assign d_in = stg_in_data[ST];
            assign s_in = stg_in_sticky[ST];
        end else begin : g_chain
            assign d_in = lvl_data[gi-1];
            assign s_in = lvl_sticky[gi-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (AWIDTH - 1 - gi))
        ) u_level (
            .data_in    (d_in),
            .op         (stg_in_op[ST]),
            .enable     (stg_in_shamt[ST][AWIDTH-1-gi]),
            .sticky_in  (s_in),
            .data_out   (lvl_data[gi]),
            .sticky_out (lvl_sticky[gi])
        );
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int FIRST_LVL = gi * LPS;
        localparam int NEXT_LVL  = ((gi + 1) * LPS < AWIDTH) ? (gi + 1) * LPS : AWIDTH;
        localparam int LAST_LVL  = (gi == STAGES - 1) ? AWIDTH - 1 : NEXT_LVL - 1;

        if (gi == 0) begin : g_head
            assign stg_in_valid[gi]  = in_valid;
            assign stg_in_data[gi]   = in_data;
            assign stg_in_op[gi]     = shift_op_e'(in_op);
            assign stg_in_shamt[gi]  = in_shamt;
            assign stg_in_tag[gi]    = in_tag;
            assign stg_in_sticky[gi] = 1'b0;
        end else begin : g_link
            assign stg_in_valid[gi]  = valid_reg[gi-1];
            assign stg_in_data[gi]   = data_reg[gi-1];
            assign stg_in_op[gi]     = op_reg[gi-1];
            assign stg_in_shamt[gi]  = shamt_reg[gi-1];
            assign stg_in_tag[gi]    = tag_reg[gi-1];
`ifdef SHIFTER_STICKY_EN
            assign stg_in_sticky[gi] = sticky_reg[gi-1];
`else
            assign stg_in_sticky[gi] = stg_out_sticky[gi-1];
`endif
        end

        if (FIRST_LVL <= LAST_LVL) begin : g_levels
            assign stg_out_data[gi]   = lvl_data[LAST_LVL];
            assign stg_out_sticky[gi] = lvl_sticky[LAST_LVL];
        end else begin : g_bypass
            assign stg_out_data[gi]   = stg_in_data[gi];
            assign stg_out_sticky[gi] = stg_in_sticky[gi];
        end

        assign valid_vec[gi] = valid_reg[gi];
        // A stage can load if it or any stage after it has a free slot, or the sink drains.
        assign stg_ready[gi] = out_ready || !(&valid_vec[STAGES-1:gi]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi] <= 1'b0;
                data_reg[gi]  <= '0;
                op_reg[gi]    <= OP_LSL;
                shamt_reg[gi] <= '0;
                tag_reg[gi]   <= '0;
            end else if (stg_ready[gi]) begin
                valid_reg[gi] <= stg_in_valid[gi];
                if (stg_in_valid[gi]) begin
                    data_reg[gi]  <= stg_out_data[gi];
                    op_reg[gi]    <= stg_in_op[gi];
                    shamt_reg[gi] <= stg_in_shamt[gi];
                    tag_reg[gi]   <= stg_in_tag[gi];
                end
            end
        end

`ifdef SHIFTER_STICKY_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sticky_reg[gi] <= 1'b0;
            end else if (stg_ready[gi] && stg_in_valid[gi]) begin
                sticky_reg[gi] <= stg_out_sticky[gi];
            end
        end
`endif
    end

    assign in_ready  = stg_ready[0];
    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];
    assign out_tag   = tag_reg[STAGES-1];
`ifdef SHIFTER_STICKY_EN
    assign out_sticky = sticky_reg[STAGES-1];
`else
    assign out_sticky = stg_out_sticky[STAGES-1];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: directed cases, backpressure, async reset,
// and randomized beats scored against an arithmetic reference model.
module tb_barrel_shifter_pipe;

    localparam int W  = 48;
    localparam int AW = 6;
    localparam int ST = 2;
    localparam int TW = 4;
`ifdef SHIFTER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_shamt = '0;
    logic [1:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_sticky;
    logic [TW-1:0] out_tag;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic in_fire, out_fire;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          sticky;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    logic          stall_prev = 1'b0;
    logic [W-1:0]  held_data;
    logic          held_sticky;
    logic [TW-1:0] held_tag;

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .out_tag    (out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    // Whole-operand arithmetic: shift by the full amount at once.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] d,
                                   input int sh, input logic [TW-1:0] tag);
        exp_t e;
        logic [W-1:0] all1;
        logic [W-1:0] lost;
        logic signed [W-1:0] sd;
        int r;
        all1 = '1;
        sd = d;
        e.tag = tag;
        e.sticky = 1'b0;
        if (sh >= W) lost = all1;
        else         lost = ~(all1 << sh);
        case (op)
            2'd0: begin
                if (sh >= W) e.data = '0;
                else         e.data = d << sh;
            end
            2'd1: begin
                if (sh >= W) e.data = '0;
                else         e.data = d >> sh;
                e.sticky = |(d & lost);
            end
            2'd2: begin
                if (sh >= W) e.data = {W{d[W-1]}};
                else         e.data = sd >>> sh;
                e.sticky = |(d & lost);
            end
            default: begin
                if (sh >= W) r = sh - W;
                else         r = sh;
                e.data = (d >> r) | (d << (W - r));
            end
        endcase
        if (!STICKY) e.sticky = 1'b0;
        return e;
    endfunction

    // One clock: score transfers seen just before the edge, then step past it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (stall_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(held_data));
            check("stall_sticky", 64'(out_sticky), 64'(held_sticky));
            check("stall_tag", 64'(out_tag), 64'(held_tag));
        end
        if (in_fire) exp_q.push_back(model(in_op, in_data, int'(in_shamt), in_tag));
        if (out_fire) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_sticky", 64'(out_sticky), 64'(e.sticky));
                check("out_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        stall_prev  = out_valid && !out_ready;
        held_data   = out_data;
        held_sticky = out_sticky;
        held_tag    = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string name, input logic [1:0] op, input logic [W-1:0] d,
                            input logic [AW-1:0] sh, input logic [TW-1:0] tag,
                            input logic [W-1:0] exp_data, input logic exp_sticky);
        int lat;
        out_ready = 1'b1;
        in_op = op; in_data = d; in_shamt = sh; in_tag = tag; in_valid = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(ST));
        check({name, "_data"}, 64'(out_data), 64'(exp_data));
        check({name, "_sticky"}, 64'(out_sticky), 64'(exp_sticky));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        @(posedge clk); #1;
        check({name, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int sent;
        int cyc;
        logic [3:0] pat;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sticky", 64'(out_sticky), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed operand cases
        send_one("lsl47", 2'd0, 48'h0000_0000_0001, 6'd47, 4'd1, 48'h8000_0000_0000, 1'b0);
        send_one("asr1", 2'd2, 48'h8000_0000_0003, 6'd1, 4'd2, 48'hC000_0000_0001, STICKY);
        send_one("ror50", 2'd3, 48'h0000_0000_0001, 6'd50, 4'd3, 48'h4000_0000_0000, 1'b0);
        send_one("lsr50", 2'd1, 48'h0000_0000_0001, 6'd50, 4'd4, 48'h0000_0000_0000, STICKY);
        send_one("asr63", 2'd2, 48'h8000_0000_0000, 6'd63, 4'd5, 48'hFFFF_FFFF_FFFF, STICKY);
        send_one("lsr0", 2'd1, 48'h1234_5678_9ABC, 6'd0, 4'd6, 48'h1234_5678_9ABC, 1'b0);

        // Back-to-back tags 0..7 with out_ready cycling 1,0,0,1
        pat = 4'b1001;
        sent = 0; cyc = 0; n_out = 0;
        exp_q.delete();
        while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            in_tag    = TW'(sent);
            in_data   = W'({$urandom, $urandom});
            in_op     = 2'($urandom_range(0, 3));
            in_shamt  = AW'($urandom_range(0, 63));
            tick();
            if (in_fire) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(n_out), 64'd8);
        check("b2b_in_bound", 64'(cyc < 200), 64'd1);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        exp_q.delete();
        in_op = 2'd0; in_shamt = '0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_tag   = TW'(5 + i);
            in_data  = W'({$urandom, $urandom}) | 48'h1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("inflight_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        check("async_out_tag", 64'(out_tag), 64'd0);
        check("async_out_sticky", 64'(out_sticky), 64'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        send_one("post_rst", 2'd1, 48'h0000_0000_00FF, 6'd4, 4'd3, 48'h0000_0000_000F, STICKY);

        // Randomized traffic against the model
        sent = 0; cyc = 0; n_out = 0;
        exp_q.delete();
        while ((sent < 10000 || exp_q.size() > 0) && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_shamt  = AW'($urandom_range(0, 63));
            in_tag    = TW'($urandom);
            case ($urandom_range(0, 3))
                0:       in_data = '1;
                1:       in_data = W'(48'h1) << $urandom_range(0, W - 1);
                default: in_data = W'({$urandom, $urandom});
            endcase
            tick();
            if (in_fire) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_count", 64'(n_out), 64'd10000);
        check("rand_in_bound", 64'(cyc < 60000), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter WIDTH, 48, datapath width in bits (>=2).
REQ-002 Parameter STAGES, 2, register stages in the pipeline (1..AWIDTH).
REQ-003 Parameter TAG_W, 4, width of the sideband tag carried alongside data.
REQ-004 Localparam AWIDTH, $clog2(WIDTH), shift-amount width.
REQ-005 Port clk, input, 1, single clock, rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port in_valid, input, 1, input beat valid.
REQ-008 Port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 Port in_data, input, WIDTH, operand.
REQ-010 Port in_shamt, input, AWIDTH, shift amount.
REQ-011 Port in_op, input, 2, operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-012 Port in_tag, input, TAG_W, opaque sideband, returned unchanged.
REQ-013 Port out_valid, output, 1, result valid.
REQ-014 Port out_ready, input, 1, downstream accepts result.
REQ-015 Port out_data, output, WIDTH, shifted result.
REQ-016 Port out_sticky, output, 1, OR of all bits shifted out (LSR/ASR only).
REQ-017 Port out_tag, output, TAG_W, tag of the beat on out_data.

Function
REQ-018 Transfer occurs on a rising edge with valid&ready high, on each side independently.
REQ-019 The AWIDTH shift levels (1,2,4,...) are processed MSB level first and split across STAGES stages, with ceil(AWIDTH/STAGES) levels per stage and any remainder in the last stage.
REQ-020 Latency is exactly STAGES cycles from input transfer to out_valid when out_ready is held high; throughput is one beat per cycle.
REQ-021 Each stage holds at most one beat and loads when empty or when its downstream stage transfers in the same cycle; in_ready equals this condition for stage 1.
REQ-022 While out_valid is high and out_ready is low, out_data, out_sticky and out_tag are held stable and no beat is lost or duplicated.
REQ-023 LSL fills with zeros on the right; LSR fills with zeros on the left; ASR fills with in_data[WIDTH-1].
REQ-024 ROR rotates right by in_shamt, or by in_shamt-WIDTH when in_shamt>=WIDTH.
REQ-025 For in_shamt>=WIDTH: LSL and LSR give 0, ASR gives all bits equal to the sign bit.
REQ-026 out_sticky is the OR of every bit shifted past bit 0 for LSR/ASR (all of in_data when in_shamt>=WIDTH); it is 0 for LSL, for ROR and for in_shamt=0.
REQ-027 Beats exit strictly in input order, with tag and op preserved per beat.

Reset
REQ-028 Asserting rst_n low immediately clears all stage-valid flags, so out_valid=0, out_data=0, out_sticky=0 and out_tag=0; in-flight beats are discarded.
REQ-029 in_ready is 1 on the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro SHIFTER_STICKY_EN: when defined, the sticky logic and its per-stage register are built; when undefined, out_sticky is tied to 0 and no sticky register exists.

Structure
REQ-031 Package hwmath_shift_pkg holds the shift_op_e enum (OP_LSL, OP_LSR, OP_ASR, OP_ROR) and the 2-bit op width constant.
REQ-032 One combinational sub-module, shift_level, implements a single power-of-two level with parameters WIDTH and DIST and ports for data in/out, op, enable and sticky in/out; it is instantiated AWIDTH times.

Verification
REQ-033 WIDTH=48, LSL, data=0x000000000001, shamt=47 -> out_data=0x800000000000 and sticky=0, with out_valid exactly STAGES cycles later.
REQ-034 ASR, data=0x800000000003, shamt=1 -> out_data=0xC00000000001 and sticky=1 (with the macro defined).
REQ-035 ROR, data=0x000000000001, shamt=50 -> out_data=0x400000000000; LSR with the same operands -> out_data=0 and sticky=1.
REQ-036 Back-to-back beats with tags 0..7 while out_ready toggles 1,0,0,1 -> all 8 results appear in order, none dropped or duplicated, and outputs are stable while stalled.
REQ-037 Assert rst_n low with 2 beats in flight -> out_valid=0 asynchronously; after release, in_ready=1 and the next beat completes normally.
REQ-038 Random op/shamt/data for 10k beats against a reference model, with the bench run once with SHIFTER_STICKY_EN and once without (out_sticky constant 0).
